fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Avalon-MM write master that puts GPU pixel output into the DRAM framebuffer.
- It is the write-side counterpart to the display scan-out reader.
- Takes a stream of (x, y, RGB555) pixels through a valid/ready handshake, buffers them in a small FIFO, and issues halfword writes with the correct byteenable.
- Also provides a hardware frame-fill command, which clears the back buffer before software swaps buffers.

Parameters:
- H_PIXELS, 800, visible pixels per line; framebuffer stride in pixels.
- V_PIXELS, 600, visible lines.
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fb_addr  in  32  framebuffer base byte address, 4-byte aligned; sampled per write
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_x  in  16  column
- pix_y  in  16  row
- pix_color  in  16  {1'b0, R5, G5, B5}
- fill_start  in  1  one-cycle request to fill the whole frame
- fill_color  in  16  fill colour, sampled with fill_start
- busy  out  1  FIFO non-empty, or state != IDLE
- fill_done  out  1  one-cycle pulse when the last fill word is accepted
- master_address  out  32  Avalon byte address
- master_write  out  1  Avalon write
- master_writedata  out  32  Avalon data
- master_byteenable  out  4  Avalon byteenable
- master_wait_request  in  1  Avalon stall

Behaviour:
- Reset values:
  - master_write=0, master_address=0, master_writedata=0, master_byteenable=0.
  - pix_ready=0 during reset, then 1 the cycle after reset deasserts.
  - busy=0, fill_done=0.
  - FIFO emptied, state=IDLE.
- Accept rule: pix_ready = !fifo_full && state != FILL.
  - Pixels with pix_x ≥ H_PIXELS or pix_y ≥ V_PIXELS are accepted but discarded: no FIFO write, no bus write.
- Address generation:
  - byte_off = (pix_y*H_PIXELS + pix_x)*2, computed as 32-bit unsigned.
  - master_address = fb_addr + (byte_off & ~3).
  - Even x: byteenable=4'b0011. Odd x: byteenable=4'b1100.
  - writedata = {color, color}.
- States: IDLE, WRITE, FILL.
  - IDLE: if FIFO is non-empty, pop an entry and register address/data/byteenable, then go to WRITE. This gives latency of 2 cycles from accept to master_write=1 when the FIFO is empty beforehand.
  - IDLE: if fill_start is seen and the block is not busy, latch fill_color, set word index=0, go to FILL.
  - IDLE: fill_start while busy is ignored. A simultaneous pixel accept and fill_start gives the pixel priority and ignores the fill.
  - WRITE: hold address/data/byteenable/write stable while master_wait_request=1.
  - WRITE: on accept (master_write && !master_wait_request), if the FIFO is non-empty, pop and load the next entry in the same cycle (back-to-back writes); otherwise deassert master_write and return to IDLE.
  - FILL: write word i at fb_addr + 4*i, data {fill_color, fill_color}, byteenable 4'b1111, for i = 0 .. H_PIXELS*V_PIXELS/2 − 1.
  - FILL: the index advances only on bus accept.
  - FILL: on acceptance of the last word, pulse fill_done, deassert master_write, return to IDLE.
- FIFO boundaries:
  - Push and pop in the same cycle while full: the push is legal because the pop frees the slot.
  - Count never exceeds FIFO_DEPTH.
- Reset mid-operation: the synchronous reset abandons any pending write regardless of wait_request. master_write=0 on the next edge and the FIFO contents are lost.

Optional Feature:
- Macro: FB_WRITE_COALESCE_EN.
- Defined: when an even-x pixel is the loaded, not-yet-issued entry and the FIFO head is x+1 on the same y, merge the two.
  - Result: one write with byteenable 4'b1111 and data {color_odd, color_even}; both entries are consumed.
  - Merging happens only in IDLE at load time, never after master_write is asserted.
- Undefined: every pixel is its own halfword write.

Decomposition:
- Shared package fb_pkg holds:
  - H_PIXELS/V_PIXELS defaults (800/600), shared with the scan-out timing.
  - FILL_WORDS = H_PIXELS*V_PIXELS/2.
  - The state enum {IDLE, WRITE, FILL}.
  - The pixel entry struct {x[15:0], y[15:0], color[15:0]}.
- Sub-module fb_write_fifo: a synchronous FIFO with push/pop/full/empty and a head peek. The peek is needed for coalescing.

Test Plan:
- Single pixel, fb_addr=0x1000_0000, x=3, y=1, color=0x7FFF, no stall → one write: addr 0x1000_0644, be 4'b1100, data 0x7FFF_7FFF, master_write high exactly 1 cycle, 2 cycles after accept.
- Pixel x=0, y=0 with master_wait_request high for 5 cycles → address/data/be/write constant for 6 cycles: 0x1000_0000, 0011.
- Clip: x=800, y=0 and x=0, y=600 → no bus write; busy stays 0.
- Backpressure: hold wait_request=1, push 9 pixels with FIFO_DEPTH=8 → pix_ready drops after 8 FIFO entries plus 1 loaded; release → all 9 written in order.
- Fill with fill_color=0x001F → 240000 writes; first addr fb_addr, last fb_addr+0xEA5FC, all be 1111, data 0x001F_001F; fill_done pulses once; pix_ready=0 throughout.
- FB_WRITE_COALESCE_EN: pixels (4,2,0x1111) then (5,2,0x2222) → single write addr fb+0xC88, be 1111, data 0x2222_1111. Without the macro → two writes, be 0011 then 1100.

Source files
------------

// File: rtl/fb_pixel_writer_pkg.sv
// Shared framebuffer definitions: default geometry, writer state encoding, pixel entry layout.
// Used by fb_pixel_writer and fb_write_fifo (optional FB_WRITE_COALESCE_EN affects those files).
package fb_pkg;

  localparam int unsigned DEF_H_PIXELS = 800;
  localparam int unsigned DEF_V_PIXELS = 600;
  localparam int unsigned FILL_WORDS   = DEF_H_PIXELS * DEF_V_PIXELS / 2;

  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FILL
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] color;
  } pix_entry_t;

  // Word-aligned byte address of the halfword holding pixel (x, y).
  function automatic logic [31:0] pix_word_addr(input logic [31:0] base,
                                                input pix_entry_t e,
                                                input int unsigned h_pixels);
    logic [31:0] off;
    off = ({16'd0, e.y} * h_pixels + {16'd0, e.x}) << 1;
    return base + {off[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// Synchronous pixel FIFO with head peek; FB_WRITE_COALESCE_EN adds a second-entry
// peek and a pop-two request used for merging adjacent pixels.
module fb_write_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pix_entry_t push_data,
  input  logic       pop,
`ifdef FB_WRITE_COALESCE_EN
  input  logic       pop_two,
  output pix_entry_t head_next,
  output logic       has_two,
`endif
  output logic       full,
  output logic       empty,
  output pix_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   pop_n;
  logic          push_ok;
  pix_entry_t    mem_q [DEPTH];

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DEPTH_CNT);
    head  = mem_q[rd_ptr_q];
    pop_n = '0;
    if (pop && !empty) pop_n = (AW+1)'(1);
`ifdef FB_WRITE_COALESCE_EN
    head_next = mem_q[rd_ptr_q + AW'(1)];
    has_two   = (count_q >= (AW+1)'(2));
    if (pop_two && has_two) pop_n = (AW+1)'(2);
`endif
    // A pop in the same cycle frees a slot, so pushing while full is legal then.
    push_ok  = push && (!full || (pop_n != '0));
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
    count_d  = count_q + (AW+1)'(push_ok) - pop_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Avalon-MM framebuffer write master: pixel stream to halfword writes, plus frame fill.
// Define FB_WRITE_COALESCE_EN to merge even/odd pixel pairs into one full-word write.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_PIXELS   = DEF_H_PIXELS,
  parameter int unsigned V_PIXELS   = DEF_V_PIXELS,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fb_addr,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic [15:0] pix_color,
  input  logic        fill_start,
  input  logic [15:0] fill_color,
  output logic        busy,
  output logic        fill_done,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  input  logic        master_wait_request
);

  localparam logic [31:0] LAST_WORD = 32'(H_PIXELS * V_PIXELS / 2 - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [31:0] fill_idx_q, fill_idx_d;
  logic [15:0] fill_color_q, fill_color_d;
  logic        fill_done_q, fill_done_d;
  logic        ready_q, ready_d;

  pix_entry_t  in_entry, head;
  logic        in_range, pix_acc;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] ld_addr, ld_data;
  logic [3:0]  ld_be;

`ifdef FB_WRITE_COALESCE_EN
  pix_entry_t  head_next, cand;
  logic        has_two, fifo_pop_two, merge_push, merge_ok;
`endif

  fb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
`ifdef FB_WRITE_COALESCE_EN
    .pop_two   (fifo_pop_two),
    .head_next (head_next),
    .has_two   (has_two),
`endif
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    in_entry  = '{x: pix_x, y: pix_y, color: pix_color};
    in_range  = (32'(pix_x) < H_PIXELS) && (32'(pix_y) < V_PIXELS);
    pix_ready = !reset && ready_q && !fifo_full && (state_q != S_FILL);
    pix_acc   = pix_valid && pix_ready;
    busy      = !fifo_empty || (state_q != S_IDLE);
    ld_addr   = pix_word_addr(fb_addr, head, H_PIXELS);
    ld_data   = {head.color, head.color};
    ld_be     = head.x[0] ? BE_HI : BE_LO;
`ifdef FB_WRITE_COALESCE_EN
    // Partner is the next FIFO entry, or the pixel arriving now if the head is alone.
    cand     = has_two ? head_next : in_entry;
    merge_ok = !head.x[0] && (has_two || (pix_acc && in_range)) &&
               (cand.y == head.y) && (cand.x == head.x + 16'd1);
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    be_d         = be_q;
    wr_d         = wr_q;
    fill_idx_d   = fill_idx_q;
    fill_color_d = fill_color_q;
    fill_done_d  = 1'b0;
    ready_d      = 1'b1;
    fifo_pop     = 1'b0;
`ifdef FB_WRITE_COALESCE_EN
    fifo_pop_two = 1'b0;
    merge_push   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = ld_addr;
          data_d   = ld_data;
          be_d     = ld_be;
          wr_d     = 1'b1;
          state_d  = S_WRITE;
`ifdef FB_WRITE_COALESCE_EN
          if (merge_ok) begin
            data_d = {cand.color, head.color};
            be_d   = BE_ALL;
            if (has_two) begin
              fifo_pop     = 1'b0;
              fifo_pop_two = 1'b1;
            end else begin
              merge_push = 1'b1;
            end
          end
`endif
        end else if (fill_start && !pix_acc) begin
          fill_color_d = fill_color;
          fill_idx_d   = '0;
          addr_d       = fb_addr;
          data_d       = {fill_color, fill_color};
          be_d         = BE_ALL;
          wr_d         = 1'b1;
          state_d      = S_FILL;
        end
      end

      S_WRITE: begin
        if (!master_wait_request) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            addr_d   = ld_addr;
            data_d   = ld_data;
            be_d     = ld_be;
          end else begin
            wr_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      S_FILL: begin
        if (!master_wait_request) begin
          if (fill_idx_q == LAST_WORD) begin
            wr_d        = 1'b0;
            fill_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            fill_idx_d = fill_idx_q + 32'd1;
            addr_d     = fb_addr + {fill_idx_d[29:0], 2'b00};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef FB_WRITE_COALESCE_EN
    fifo_push = pix_acc && in_range && !merge_push;
`else
    fifo_push = pix_acc && in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      wr_q         <= 1'b0;
      fill_idx_q   <= '0;
      fill_color_q <= '0;
      fill_done_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      be_q         <= be_d;
      wr_q         <= wr_d;
      fill_idx_q   <= fill_idx_d;
      fill_color_q <= fill_color_d;
      fill_done_q  <= fill_done_d;
      ready_q      <= ready_d;
    end
  end

  assign master_address    = addr_q;
  assign master_writedata  = data_q;
  assign master_byteenable = be_q;
  assign master_write      = wr_q;
  assign fill_done         = fill_done_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer (800-pixel stride, 8 lines so a full fill stays short).
module tb_fb_pixel_writer;

  localparam int unsigned H     = 800;
  localparam int unsigned V     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NFILL = H * V / 2;
  localparam logic [31:0] FB    = 32'h1000_0000;

  logic        clk, reset;
  logic [31:0] fb_addr;
  logic        pix_valid, pix_ready;
  logic [15:0] pix_x, pix_y, pix_color;
  logic        fill_start;
  logic [15:0] fill_color;
  logic        busy, fill_done;
  logic [31:0] master_address, master_writedata;
  logic        master_write, master_wait_request;
  logic [3:0]  master_byteenable;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_cnt   = 0;

  fb_pixel_writer #(.H_PIXELS(H), .V_PIXELS(V), .FIFO_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fb_addr             (fb_addr),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .pix_x               (pix_x),
    .pix_y               (pix_y),
    .pix_color           (pix_color),
    .fill_start          (fill_start),
    .fill_color          (fill_color),
    .busy                (busy),
    .fill_done           (fill_done),
    .master_address      (master_address),
    .master_write        (master_write),
    .master_writedata    (master_writedata),
    .master_byteenable   (master_byteenable),
    .master_wait_request (master_wait_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t pix_exp(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
    exp_t e;
    logic [31:0] off;
    off    = (32'(y) * H + 32'(x)) * 2;
    e.addr = FB + (off & 32'hFFFF_FFFC);
    e.data = {c, c};
    e.be   = x[0] ? 4'b1100 : 4'b0011;
    return e;
  endfunction

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves pix_valid high and returns at posedge+1 after the accept edge.
  task automatic send_pixel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
    int t;
    pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = c;
    t = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      t++;
      if (t > 50) begin
        check("pix_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int limit);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    check(name, {exp_q.size() == 0, !busy}, 2'b11);
  endtask

  // Monitor: every accepted bus write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (fill_done) fd_cnt++;
      if (master_write && !master_wait_request) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h be %b, required no write",
                   master_address, master_writedata, master_byteenable);
        end else begin
          mon_e = exp_q.pop_front();
          check("bus_write", {master_address, master_writedata, master_byteenable},
                {mon_e.addr, mon_e.data, mon_e.be});
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base, rdy_hi, t, quiet;
    reset = 1'b1; fb_addr = FB; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
    fill_start = 1'b0; fill_color = '0; master_wait_request = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bus", {master_address, master_writedata, master_byteenable, master_write}, '0);
    check("rst_status", {busy, fill_done, pix_ready}, 3'b000);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_first_cycle", pix_ready, 1'b0);
    @(negedge clk);
    check("ready_after_reset", pix_ready, 1'b1);

    // Single pixel latency and pulse width
    @(posedge clk); #1;
    expect_write(32'h1000_0644, 32'h7FFF_7FFF, 4'b1100);
    send_pixel(16'd3, 16'd1, 16'h7FFF);
    pix_valid = 1'b0;
    @(negedge clk); check("lat_cycle1", master_write, 1'b0);
    @(negedge clk); check("lat_cycle2", master_write, 1'b1);
    @(negedge clk); check("write_one_cycle", master_write, 1'b0);

    // Stall: outputs held for 6 cycles
    @(posedge clk); #1 master_wait_request = 1'b1;
    expect_write(32'h1000_0000, 32'h1234_1234, 4'b0011);
    send_pixel(16'd0, 16'd0, 16'h1234);
    pix_valid = 1'b0;
    t = 0;
    while (!master_write && t < 10) begin @(negedge clk); t++; end
    check("stall_write_seen", master_write, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      check("stall_hold", {master_write, master_address, master_writedata, master_byteenable},
            {1'b1, 32'h1000_0000, 32'h1234_1234, 4'b0011});
      if (i == 5) begin @(posedge clk); #1 master_wait_request = 1'b0; end
      if (i < 6) @(negedge clk);
    end
    @(negedge clk); check("stall_release", master_write, 1'b0);

    // Clipping, then last in-range pixel
    @(posedge clk); #1;
    send_pixel(16'd800, 16'd0, 16'h5555);
    send_pixel(16'd0, 16'd8, 16'h6666);
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("clip_idle", {busy, master_write}, 2'b00);
    end
    @(posedge clk); #1;
    expect_write(32'h1000_31FC, 32'h4321_4321, 4'b1100);
    send_pixel(16'd799, 16'd7, 16'h4321);
    pix_valid = 1'b0;
    drain("corner_drain", 20);

    // Backpressure: 8 in FIFO + 1 loaded
    @(posedge clk); #1 master_wait_request = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pix_exp(16'(10 + i), 16'd3, 16'(16'h0100 + i)));
      send_pixel(16'(10 + i), 16'd3, 16'(16'h0100 + i));
    end
    pix_valid = 1'b0;
    @(negedge clk);
    check("bp_ready_low", {pix_ready, busy}, 2'b01);
    @(posedge clk); #1 master_wait_request = 1'b0;
    drain("bp_drain", 40);

    // Fill request while busy is ignored
    @(posedge clk); #1 master_wait_request = 1'b1;
    exp_q.push_back(pix_exp(16'd20, 16'd4, 16'h0AAA));
    send_pixel(16'd20, 16'd4, 16'h0AAA);
    pix_valid = 1'b0;
    fd_base = fd_cnt;
    @(posedge clk); #1 fill_start = 1'b1; fill_color = 16'h7C00;
    @(posedge clk); #1 fill_start = 1'b0; master_wait_request = 1'b0;
    drain("busy_fill_drain", 20);
    repeat (3) @(negedge clk);
    check("busy_fill_ignored", {fd_cnt - fd_base, master_write}, 33'd0);

    // Frame fill with random stalls
    @(posedge clk); #1;
    for (int i = 0; i < int'(NFILL); i++)
      expect_write(FB + 32'(4 * i), 32'h001F_001F, 4'b1111);
    fd_base = fd_cnt;
    rdy_hi = 0;
    fill_start = 1'b1; fill_color = 16'h001F;
    @(posedge clk); #1 fill_start = 1'b0; fill_color = 16'hFFFF;
    t = 0;
    while (exp_q.size() != 0 && t < int'(4 * NFILL)) begin
      @(posedge clk); #1 master_wait_request = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (master_write && pix_ready) rdy_hi++;
      t++;
    end
    @(posedge clk); #1 master_wait_request = 1'b0;
    repeat (3) @(negedge clk);
    check("fill_all_written", exp_q.size(), 0);
    check("fill_ready_low", rdy_hi, 0);
    check("fill_done_once", fd_cnt - fd_base, 1);
    check("fill_idle", {busy, master_write}, 2'b00);

    // Adjacent even/odd pair on one line
    @(posedge clk); #1;
`ifdef FB_WRITE_COALESCE_EN
    expect_write(32'h1000_0C88, 32'h2222_1111, 4'b1111);
`else
    expect_write(32'h1000_0C88, 32'h1111_1111, 4'b0011);
    expect_write(32'h1000_0C88, 32'h2222_2222, 4'b1100);
`endif
    send_pixel(16'd4, 16'd2, 16'h1111);
    send_pixel(16'd5, 16'd2, 16'h2222);
    pix_valid = 1'b0;
    drain("pair_drain", 20);

    // Reset mid-operation abandons the stalled write and queued pixels
    @(posedge clk); #1 master_wait_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pix_exp(16'(30 + 2 * i), 16'd5, 16'h0F0F));
      send_pixel(16'(30 + 2 * i), 16'd5, 16'h0F0F);
    end
    pix_valid = 1'b0;
    @(negedge clk); check("pre_reset_write", master_write, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; master_wait_request = 1'b0;
    exp_q.delete();
    @(negedge clk); check("post_reset_state", {master_write, busy}, 2'b00);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (master_write || busy) quiet++;
    end
    check("post_reset_quiet", quiet, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
